// File: rtl/dec_key_sequencer_128.sv
// dec_key_sequencer_128: issues SWAN64 128-bit decryption subkeys over valid/ready; optional DEC_KS_REPLAY_EN adds replay of the last loaded key/delta
module dec_key_sequencer_128 #(
  parameter int KEY_SIZE = 128,
  parameter int SIDE_SIZE = 32,
  parameter int PD = 24,
  parameter logic [31:0] DELTA0 = 32'h9e3779b9,
  parameter int NUM_SK = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [KEY_SIZE-1:0]  key_in,
  input  logic [SIDE_SIZE-1:0] delta_in,
  input  logic                 flush,
`ifdef DEC_KS_REPLAY_EN
  input  logic                 replay,
`endif
  output logic [SIDE_SIZE-1:0] sk,
  output logic                 sk_valid,
  input  logic                 sk_ready,
  output logic [CNT_W-1:0]     sk_index,
  output logic                 busy,
  output logic                 done
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t state;
  logic [KEY_SIZE-1:0] key_reg, sub_key, next_key;
  logic [SIDE_SIZE-1:0] delta_reg;
  logic [CNT_W-1:0] cnt;
  logic last;
`ifdef DEC_KS_REPLAY_EN
  logic [KEY_SIZE+SIDE_SIZE-1:0] shadow;
`endif
  // one key-schedule step: subtract delta from the low word, then rotate the whole state left
  always_comb begin
    sub_key = {key_reg[KEY_SIZE-1:SIDE_SIZE], key_reg[SIDE_SIZE-1:0] - delta_reg};
    next_key = {sub_key[KEY_SIZE-PD-1:0], sub_key[KEY_SIZE-1:KEY_SIZE-PD]};
    last = cnt == CNT_W'(NUM_SK - 1);
  end
  assign sk = key_reg[SIDE_SIZE-1:0];
  assign sk_index = cnt;
  // control FSM with registered handshake/status outputs; flush outranks everything outside IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      key_reg <= '0;
      delta_reg <= '0;
      cnt <= '0;
      sk_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
`ifdef DEC_KS_REPLAY_EN
      shadow <= '0;
`endif
    end else if (flush && state != IDLE) begin
      state <= IDLE;
      cnt <= '0;
      sk_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && !flush) begin
            key_reg <= key_in;
            delta_reg <= delta_in;
            cnt <= '0;
            busy <= 1'b1;
            state <= LOAD;
`ifdef DEC_KS_REPLAY_EN
            shadow <= {key_in, delta_in};
          end else if (replay && !flush) begin
            key_reg <= shadow[KEY_SIZE+SIDE_SIZE-1:SIDE_SIZE];
            delta_reg <= shadow[SIDE_SIZE-1:0];
            cnt <= '0;
            busy <= 1'b1;
            state <= LOAD;
`endif
          end
        end
        LOAD: begin
          sk_valid <= 1'b1;
          state <= RUN;
        end
        RUN: begin
          if (sk_ready) begin
            key_reg <= next_key;
            delta_reg <= delta_reg - DELTA0;
            cnt <= cnt + 1'b1;
            if (last) begin
              sk_valid <= 1'b0;
              busy <= 1'b0;
              done <= 1'b1;
              state <= DONE;
            end
          end
        end
        default: begin
          done <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dec_key_sequencer_128.sv
// tb_dec_key_sequencer_128: randomized and directed self-checking bench for dec_key_sequencer_128
module tb_dec_key_sequencer_128;
  localparam int NUM_SK = 32;
  localparam logic [31:0] DELTA0 = 32'h9e3779b9;
  logic clk = 0, rst_n = 0, start = 0, flush = 0, sk_ready = 0, replay = 0;
  logic [127:0] key_in = '0;
  logic [31:0] delta_in = '0;
  logic [31:0] sk;
  logic sk_valid, busy, done;
  logic [5:0] sk_index;
  int n_chk = 0, n_fail = 0;
  logic [31:0] exp_sk [NUM_SK];

  dec_key_sequencer_128 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .delta_in(delta_in),
    .flush(flush),
`ifdef DEC_KS_REPLAY_EN
    .replay(replay),
`endif
    .sk(sk), .sk_valid(sk_valid), .sk_ready(sk_ready), .sk_index(sk_index),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference: key held as four words w[0] (most significant) .. w[3] (subkey word)
  task automatic gen(input logic [127:0] k, input logic [31:0] d);
    logic [31:0] w [4];
    logic [127:0] v;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int n = 0; n < NUM_SK; n++) begin
      exp_sk[n] = w[3];
      w[3] = w[3] - d;
      v = {w[0], w[1], w[2], w[3]};
      v = (v << 24) | (v >> 104);
      for (int i = 0; i < 4; i++) w[i] = v[127-32*i -: 32];
      d = d - DELTA0;
    end
  endtask

  task automatic run(input logic [127:0] k, input logic [31:0] d, input bit full, input bit use_replay);
    int idx, cyc;
    if (!use_replay) gen(k, d);
    @(negedge clk);
    if (use_replay) begin replay = 1; key_in = ~k; delta_in = ~d; end
    else begin start = 1; key_in = k; delta_in = d; end
    sk_ready = 0;
    @(negedge clk);
    start = 0; replay = 0;
    chk("load_busy", busy, 1);
    chk("load_valid", sk_valid, 0);
    idx = 0; cyc = 0;
    while (idx < NUM_SK && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (!sk_valid) begin chk("valid_drop", sk_valid, 1); break; end
      chk("sk", sk, exp_sk[idx]);
      chk("sk_index", sk_index, idx);
      sk_ready = full ? 1'b1 : 1'($urandom_range(0, 1));
      if (sk_ready) idx++;
    end
    chk("stream_complete", idx, NUM_SK);
    if (full) chk("full_rate_cycles", cyc, NUM_SK);
    @(negedge clk);
    sk_ready = 0;
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    chk("done_valid", sk_valid, 0);
    @(negedge clk);
    chk("done_once", done, 0);
  endtask

  initial begin
    int k;
    #12;
    chk("rst_sk", sk, 0);
    chk("rst_valid", sk_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_index", sk_index, 0);
    rst_n = 1;
    // directed basic sequence with backpressure, ignored start, and flush
    @(negedge clk);
    key_in = '0; delta_in = 32'h9e3779b9; start = 1;
    @(negedge clk);
    start = 0;
    chk("b_load_valid", sk_valid, 0);
    @(negedge clk);
    chk("b_valid", sk_valid, 1);
    chk("b_sk0", sk, 32'h0);
    chk("b_idx0", sk_index, 0);
    sk_ready = 1;
    @(negedge clk);
    sk_ready = 0;
    chk("b_sk1", sk, 32'h47000000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_sk", sk, 32'h47000000);
      chk("bp_idx", sk_index, 1);
    end
    sk_ready = 1;
    @(negedge clk);
    sk_ready = 0;
    chk("b_sk2", sk, 32'h0);
    chk("b_idx2", sk_index, 2);
    start = 1; key_in = {4{32'hdeadbeef}};
    @(negedge clk);
    start = 0;
    chk("start_ign_idx", sk_index, 2);
    chk("start_ign_sk", sk, 32'h0);
    chk("start_ign_busy", busy, 1);
    sk_ready = 1;
    k = 0;
    while (sk_index != 10 && k < 50) begin @(negedge clk); k++; end
    sk_ready = 0;
    chk("reach_idx10", sk_index, 10);
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk("flush_valid", sk_valid, 0);
    chk("flush_busy", busy, 0);
    chk("flush_done", done, 0);
    chk("flush_idx", sk_index, 0);
    // full-rate and randomized-backpressure runs against the model
    run(128'h0, 32'h9e3779b9, 1, 0);
    for (int r = 0; r < 4; r++)
      run({$urandom, $urandom, $urandom, $urandom}, $urandom, r == 0, 0);
`ifdef DEC_KS_REPLAY_EN
    run({$urandom, $urandom, $urandom, $urandom}, $urandom, 0, 0);
    run('0, '0, 1, 1);
    run(128'h0, 32'h9e3779b9, 1, 0);
    run('0, '0, 0, 1);
`endif
    // async reset mid-run, asserted between edges
    @(negedge clk);
    start = 1; key_in = {4{32'h12345678}}; delta_in = 32'h1;
    @(negedge clk);
    start = 0; sk_ready = 1;
    repeat (3) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("arst_sk", sk, 0);
    chk("arst_valid", sk_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_idx", sk_index, 0);
    @(negedge clk);
    rst_n = 1; sk_ready = 0;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_valid", sk_valid, 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/dec_key_sequencer_128.md
Name: dec_key_sequencer_128

Overview:
- Sequential controller that drives the SWAN64 128-bit decryption key-schedule step (the sk-minus-delta, rotate, delta-decrement datapath) over a full decryption.
- Loads the final-round key state and delta once, then emits one 32-bit subkey per valid/ready handshake until NUM_SK subkeys have been issued.
- Sits between the key-load interface and the decryption round engine.

Parameters:
- KEY_SIZE, 128: key state width.
- SIDE_SIZE, 32: subkey/delta width.
- PD, 24: left-rotate amount applied after the subtract (bit 0 = MSB).
- DELTA0, 32'h9e3779b9: per-step delta decrement.
- NUM_SK, 32: subkeys issued per load; must be at least 1.
- CNT_W, 6: subkey index counter width; must satisfy 2^CNT_W > NUM_SK.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  load request; sampled only in IDLE.
- key_in  input  128  initial decryption key state, [0:127].
- delta_in  input  32  initial delta, [0:31].
- flush  input  1  synchronous abort.
- sk  output  32  current subkey = key_reg[96:127].
- sk_valid  output  1  sk is valid.
- sk_ready  input  1  consumer accepts sk.
- sk_index  output  CNT_W  index of the current subkey, 0..NUM_SK-1.
- busy  output  1  high in LOAD or RUN.
- done  output  1  one-cycle pulse after the last subkey is accepted.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; key_reg=0, delta_reg=0, cnt=0; sk_valid=0, busy=0, done=0, sk=0, sk_index=0.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - start=1 latches key_in into key_reg and delta_in into delta_reg, clears cnt, and goes to LOAD.
  - start in any other state is ignored.
- LOAD:
  - One cycle; busy=1, sk_valid=0.
  - Goes to RUN unconditionally.
  - Start-to-first-valid latency is 2 cycles.
- RUN: sk_valid=1, busy=1, sk_index=cnt.
  - On sk_valid&sk_ready, in the same edge:
    - key_reg <= rotl24({key_reg[0:95], key_reg[96:127]-delta_reg}).
    - delta_reg <= delta_reg-DELTA0.
    - cnt <= cnt+1.
  - Without a handshake, sk, sk_index, key_reg and delta_reg hold; sk is stable under backpressure.
  - A handshake with cnt==NUM_SK-1 goes to DONE; sk_valid drops in the next cycle.
  - With sk_ready held high, one subkey is issued per cycle.
- DONE: done=1 for exactly one cycle, busy=0, sk_valid=0; then IDLE. key_reg keeps the post-final-step value.
- Arithmetic: all subtracts are modulo 2^32; the delta wrap through zero is legal and unflagged.
- flush:
  - Takes priority over the handshake and over start.
  - From LOAD, RUN or DONE: next state IDLE, sk_valid=0, done not asserted, cnt=0, key_reg/delta_reg unchanged.
  - No effect in IDLE.
- Reset mid-RUN: immediate return to the reset values; no done pulse.

Optional Feature:
- Macro: DEC_KS_REPLAY_EN.
- Enabled:
  - Adds input replay (1 bit) and a 160-bit shadow register that captures key_in and delta_in on every load.
  - replay=1 in IDLE restores key_reg/delta_reg from the shadow and enters LOAD with no key_in needed.
  - If start and replay are both high, start wins.
  - The shadow resets to 0.
- Disabled: no replay port and no shadow register; behaviour is otherwise identical.

Test Plan:
- Basic sequence: key_in=128'h0, delta_in=32'h9e3779b9, start, sk_ready=1.
  - Response: first sk_valid 2 cycles after start.
  - sk sequence: 0x00000000, 0x47000000, 0x00000000 at indices 0, 1, 2.
  - After the first step, delta_reg=0.
- Full run at full rate: NUM_SK=32, sk_ready=1 → exactly 32 handshakes on consecutive cycles, done pulses once in the cycle after handshake 31, busy falls with it.
- Backpressure: hold sk_ready=0 for 5 cycles at index 1 → sk stays 0x47000000, sk_index stays 1; a single advance follows release.
- Start/flush interaction: start during RUN is ignored with no state change; flush at index 10 → IDLE next cycle with sk_valid=0 and no done; a fresh start restarts at index 0.
- Async reset: drop rst_n mid-RUN, between clock edges → all outputs 0 before the next edge; after release the block stays in IDLE.
- With DEC_KS_REPLAY_EN: run a full sequence, then pulse replay → the identical 32-subkey stream is reproduced, starting 0x00000000, 0x47000000.
